// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU sequencer: opcodes, enable indices, state encoding.
// ALU_SEQ_MULS_EN adds the MUL state used by the signed shift-add multiplier.
package alu_seq_pkg;

  localparam int DATA_W = 8;
  localparam int RSP_W  = 16;

  localparam logic [3:0] OP_INV  = 4'd0;
  localparam logic [3:0] OP_ANDL = 4'd1;
  localparam logic [3:0] OP_EQU  = 4'd2;
  localparam logic [3:0] OP_ORL  = 4'd3;
  localparam logic [3:0] OP_DEC  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_INC  = 4'd7;
  localparam logic [3:0] OP_CMP  = 4'd8;
  localparam logic [3:0] OP_MULS = 4'd9;
  localparam logic [3:0] OP_NEG  = 4'd10;

  // Bit positions in the one-hot operation enable vector
  localparam int EN_INV  = 0;
  localparam int EN_ANDL = 1;
  localparam int EN_EQU  = 2;
  localparam int EN_ORL  = 3;
  localparam int EN_DEC  = 4;
  localparam int EN_ADD  = 5;
  localparam int EN_SUB  = 6;
  localparam int EN_INC  = 7;
  localparam int EN_CMP  = 8;
  localparam int EN_MULS = 9;
  localparam int EN_NEG  = 10;
  localparam int EN_ILL  = 11;
  localparam int EN_W    = 12;

  typedef logic [EN_W-1:0] op_en_t;

`ifdef ALU_SEQ_MULS_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/alu_decoder.sv
// Turns the latched opcode into one-hot operation enables.
// Opcode 9 decodes as muls only when ALU_SEQ_MULS_EN is defined, otherwise as illegal.
module alu_decoder
  import alu_seq_pkg::*;
(
  input  logic [3:0] op,
  output op_en_t     en
);

  // Opcode to one-hot enable lookup
  always_comb begin
    en = {EN_W{1'b0}};
    case (op)
      OP_INV:  en[EN_INV]  = 1'b1;
      OP_ANDL: en[EN_ANDL] = 1'b1;
      OP_EQU:  en[EN_EQU]  = 1'b1;
      OP_ORL:  en[EN_ORL]  = 1'b1;
      OP_DEC:  en[EN_DEC]  = 1'b1;
      OP_ADD:  en[EN_ADD]  = 1'b1;
      OP_SUB:  en[EN_SUB]  = 1'b1;
      OP_INC:  en[EN_INC]  = 1'b1;
      OP_CMP:  en[EN_CMP]  = 1'b1;
`ifdef ALU_SEQ_MULS_EN
      OP_MULS: en[EN_MULS] = 1'b1;
`endif
      OP_NEG:  en[EN_NEG]  = 1'b1;
      default: en[EN_ILL]  = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Two-requester round-robin ALU sequencer with a held response until rsp_ready.
// ALU_SEQ_MULS_EN enables the 8-cycle signed shift-add multiply (op 9).
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [3:0]        op0,
  input  logic [3:0]        op1,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [RSP_W-1:0]  rsp_data,
  output logic              rsp_zero,
  output logic              rsp_carry,
  output logic              rsp_err
);

  state_t              state_r, state_s;
  logic                last_r;
  logic [1:0]          grant_s;
  logic [3:0]          op_in_s, op_r;
  logic [DATA_W-1:0]   a_in_s, b_in_s, a_r, b_r;
  logic                id_r;
  op_en_t              en_s;
  logic [RSP_W-1:0]    res_s;
  logic [DATA_W:0]     wide_s;
  logic                carry_s, err_s;
`ifdef ALU_SEQ_MULS_EN
  logic                is_mul_s;
  logic [RSP_W-1:0]    acc_r, acc_s, mcand_r;
  logic [DATA_W-1:0]   mplier_r;
  logic [2:0]          cnt_r;
`endif

  alu_decoder u_dec (
    .op (op_r),
    .en (en_s)
  );

  // Round-robin grant; last_r holds the requester granted most recently
  always_comb begin
    grant_s = 2'b00;
    if (state_r == ST_IDLE) begin
      case (req_valid)
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        2'b11:   grant_s = last_r ? 2'b01 : 2'b10;
        default: grant_s = 2'b00;
      endcase
    end else begin
      grant_s = 2'b00;
    end
  end

  assign req_ready = rst_n ? grant_s : 2'b00;
  assign op_in_s   = grant_s[1] ? op1 : op0;
  assign a_in_s    = grant_s[1] ? a1  : a0;
  assign b_in_s    = grant_s[1] ? b1  : b0;
`ifdef ALU_SEQ_MULS_EN
  assign is_mul_s  = (op_in_s == OP_MULS);
`endif

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s != 2'b00) begin
`ifdef ALU_SEQ_MULS_EN
          state_s = is_mul_s ? ST_MUL : ST_EXEC;
`else
          state_s = ST_EXEC;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: state_s = ST_DONE;
`ifdef ALU_SEQ_MULS_EN
      ST_MUL: begin
        if (cnt_r == 3'd7) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_MUL;
        end
      end
`endif
      ST_DONE: begin
        if (rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Single-cycle ALU on the latched operands; carry doubles as borrow for sub/dec
  always_comb begin
    res_s   = 16'h0000;
    wide_s  = 9'h000;
    carry_s = 1'b0;
    err_s   = 1'b0;
    case (1'b1)
      en_s[EN_INV]:  res_s = {8'h00, ~a_r};
      en_s[EN_ANDL]: res_s = {8'h00, a_r & b_r};
      en_s[EN_EQU]:  res_s = {15'h0000, (a_r == b_r)};
      en_s[EN_ORL]:  res_s = {8'h00, a_r | b_r};
      en_s[EN_DEC]: begin
        wide_s  = {1'b0, a_r} - 9'd1;
        res_s   = {8'h00, wide_s[DATA_W-1:0]};
        carry_s = wide_s[DATA_W];
      end
      en_s[EN_ADD]: begin
        wide_s  = {1'b0, a_r} + {1'b0, b_r};
        res_s   = {8'h00, wide_s[DATA_W-1:0]};
        carry_s = wide_s[DATA_W];
      end
      en_s[EN_SUB]: begin
        wide_s  = {1'b0, a_r} - {1'b0, b_r};
        res_s   = {8'h00, wide_s[DATA_W-1:0]};
        carry_s = wide_s[DATA_W];
      end
      en_s[EN_INC]: begin
        wide_s  = {1'b0, a_r} + 9'd1;
        res_s   = {8'h00, wide_s[DATA_W-1:0]};
        carry_s = wide_s[DATA_W];
      end
      en_s[EN_CMP]:  res_s = {14'h0000, (a_r == b_r), (a_r < b_r)};
      en_s[EN_MULS]: res_s = 16'h0000;
      en_s[EN_NEG]:  res_s = {8'h00, 8'h00 - a_r};
      en_s[EN_ILL]:  err_s = 1'b1;
      default:       err_s = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MULS_EN
  // Shift-add step; multiplier bit 7 has negative weight in two's complement
  always_comb begin
    acc_s = acc_r;
    if (mplier_r[0]) begin
      acc_s = (cnt_r == 3'd7) ? (acc_r - mcand_r) : (acc_r + mcand_r);
    end else begin
      acc_s = acc_r;
    end
  end
`endif

  // State, operand latch and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      last_r    <= 1'b1;
      op_r      <= 4'd0;
      a_r       <= 8'h00;
      b_r       <= 8'h00;
      id_r      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= 16'h0000;
      rsp_zero  <= 1'b0;
      rsp_carry <= 1'b0;
      rsp_err   <= 1'b0;
`ifdef ALU_SEQ_MULS_EN
      acc_r     <= 16'h0000;
      mcand_r   <= 16'h0000;
      mplier_r  <= 8'h00;
      cnt_r     <= 3'd0;
`endif
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_IDLE: begin
          if (grant_s != 2'b00) begin
            op_r   <= op_in_s;
            a_r    <= a_in_s;
            b_r    <= b_in_s;
            id_r   <= grant_s[1];
            last_r <= grant_s[1];
`ifdef ALU_SEQ_MULS_EN
            acc_r    <= 16'h0000;
            mcand_r  <= {{(RSP_W-DATA_W){a_in_s[DATA_W-1]}}, a_in_s};
            mplier_r <= b_in_s;
            cnt_r    <= 3'd0;
`endif
          end
        end
        ST_EXEC: begin
          rsp_valid <= 1'b1;
          rsp_id    <= id_r;
          rsp_data  <= res_s;
          rsp_zero  <= (res_s == 16'h0000);
          rsp_carry <= carry_s;
          rsp_err   <= err_s;
        end
`ifdef ALU_SEQ_MULS_EN
        ST_MUL: begin
          acc_r    <= acc_s;
          mcand_r  <= {mcand_r[RSP_W-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[DATA_W-1:1]};
          cnt_r    <= cnt_r + 3'd1;
          if (cnt_r == 3'd7) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_r;
            rsp_data  <= acc_s;
            rsp_zero  <= (acc_s == 16'h0000);
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b0;
          end
        end
`endif
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus queues expected responses, a monitor checks them.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready;
  logic [3:0]  op0, op1;
  logic [7:0]  a0, b0, a1, b1;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_zero, rsp_carry, rsp_err;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        id;
    logic [15:0] data;
    logic        z, c, e;
    int          at;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   seen  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares every cycle the response is presented, pops on handshake
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got data %0h with nothing outstanding (cycle %0d)", rsp_data, cyc);
      end else begin
        if (!seen) check("rsp_latency", cyc, q[0].at);
        seen = 1'b1;
        check("rsp_id", {31'd0, rsp_id}, {31'd0, q[0].id});
        check("rsp_data", {16'd0, rsp_data}, {16'd0, q[0].data});
        check("rsp_flags", {29'd0, rsp_zero, rsp_carry, rsp_err}, {29'd0, q[0].z, q[0].c, q[0].e});
        check("busy_no_grant", {30'd0, req_ready}, 32'd0);
        if (rsp_ready) begin
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end else begin
      seen = 1'b0;
    end
  end

  task automatic grant(input logic [1:0] vld, input logic [1:0] exp_g, input logic [15:0] d,
                       input logic z, input logic c, input logic e, input int lat,
                       input logic [1:0] after_v);
    exp_t x;
    int   t = 0;
    req_valid = vld;
    @(negedge clk);
    while (req_ready == 2'b00 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("req_ready", {30'd0, req_ready}, {30'd0, exp_g});
    if (req_ready != 2'b00) begin
      x.id = exp_g[1]; x.data = d; x.z = z; x.c = c; x.e = e; x.at = cyc + lat;
      q.push_back(x);
    end
    @(posedge clk);
    #2;
    req_valid = after_v;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 40) begin
      @(posedge clk);
      t++;
    end
    #2;
    check("drain", q.size(), 32'd0);
  endtask

  task automatic run1(input logic id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] d, input logic z, input logic c, input logic e, input int lat);
    if (id) begin
      op1 = op; a1 = a; b1 = b;
    end else begin
      op0 = op; a0 = a; b0 = b;
    end
    grant(id ? 2'b10 : 2'b01, id ? 2'b10 : 2'b01, d, z, c, e, lat, 2'b00);
    // Operands move after the accept; the queued response must not change
    op0 = 4'd3; a0 = ~a; b0 = ~b;
    op1 = 4'd3; a1 = ~a; b1 = ~b;
    drain();
  endtask

  task automatic check_all_zero(input string name);
    check(name, {24'd0, req_ready, rsp_valid, rsp_id, rsp_zero, rsp_carry, rsp_err, rsp_data != 16'h0000},
          32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
    op0 = 4'd0; op1 = 4'd0; a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("reset_outputs");
    rst_n = 1'b1;

    // Two-way tie straight out of reset, then the other requester
    op0 = 4'd5; a0 = 8'h01; b0 = 8'h01;
    op1 = 4'd7; a1 = 8'h41; b1 = 8'h00;
    grant(2'b11, 2'b01, 16'h0002, 1'b0, 1'b0, 1'b0, 2, 2'b11);
    grant(2'b11, 2'b10, 16'h0042, 1'b0, 1'b0, 1'b0, 2, 2'b00);
    drain();

    run1(1'b0, 4'd5,  8'hF0, 8'h20, 16'h0010, 1'b0, 1'b1, 1'b0, 2);
    run1(1'b1, 4'd5,  8'h12, 8'h34, 16'h0046, 1'b0, 1'b0, 1'b0, 2);
    run1(1'b1, 4'd6,  8'h10, 8'h20, 16'h00F0, 1'b0, 1'b1, 1'b0, 2);
    run1(1'b0, 4'd6,  8'h20, 8'h10, 16'h0010, 1'b0, 1'b0, 1'b0, 2);
    run1(1'b0, 4'd7,  8'hFF, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b0, 2);
    run1(1'b0, 4'd4,  8'h00, 8'h00, 16'h00FF, 1'b0, 1'b1, 1'b0, 2);
    run1(1'b1, 4'd0,  8'h5A, 8'h00, 16'h00A5, 1'b0, 1'b0, 1'b0, 2);
    run1(1'b0, 4'd2,  8'h33, 8'h33, 16'h0001, 1'b0, 1'b0, 1'b0, 2);
    run1(1'b0, 4'd2,  8'h33, 8'h34, 16'h0000, 1'b1, 1'b0, 1'b0, 2);
    run1(1'b1, 4'd3,  8'h00, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 2);
    run1(1'b0, 4'd8,  8'h03, 8'h07, 16'h0001, 1'b0, 1'b0, 1'b0, 2);
    run1(1'b1, 4'd8,  8'h07, 8'h07, 16'h0002, 1'b0, 1'b0, 1'b0, 2);
    run1(1'b0, 4'd10, 8'h01, 8'h00, 16'h00FF, 1'b0, 1'b0, 1'b0, 2);
    run1(1'b1, 4'd15, 8'h12, 8'h34, 16'h0000, 1'b1, 1'b0, 1'b1, 2);

    // Illegal op under backpressure with both requesters waiting
    rsp_ready = 1'b0;
    op0 = 4'd12; a0 = 8'h55; b0 = 8'hAA;
    op1 = 4'd5;  a1 = 8'hFF; b1 = 8'h01;
    grant(2'b01, 2'b01, 16'h0000, 1'b1, 1'b0, 1'b1, 2, 2'b11);
    op0 = 4'd5; a0 = 8'h00;
    repeat (6) @(posedge clk);
    #2;
    check("held_valid", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    grant(2'b11, 2'b10, 16'h0000, 1'b1, 1'b1, 1'b0, 2, 2'b00);
    drain();

`ifdef ALU_SEQ_MULS_EN
    run1(1'b1, 4'd9, 8'hFD, 8'h07, 16'hFFEB, 1'b0, 1'b0, 1'b0, 9);
    run1(1'b0, 4'd9, 8'h80, 8'h80, 16'h4000, 1'b0, 1'b0, 1'b0, 9);
    // Abort during the fourth multiply cycle
    op0 = 4'd9; a0 = 8'h7F; b0 = 8'h7F;
    grant(2'b01, 2'b01, 16'h3F01, 1'b0, 1'b0, 1'b0, 9, 2'b00);
    repeat (3) @(posedge clk);
    #2;
`else
    run1(1'b0, 4'd9, 8'hFD, 8'h07, 16'h0000, 1'b1, 1'b0, 1'b1, 2);
    // Abort while the response is presented and held
    rsp_ready = 1'b0;
    op0 = 4'd7; a0 = 8'h01; b0 = 8'h00;
    grant(2'b01, 2'b01, 16'h0002, 1'b0, 1'b0, 1'b0, 2, 2'b00);
    @(posedge clk);
    #2;
    check("pre_abort_valid", {31'd0, rsp_valid}, 32'd1);
`endif
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    check_all_zero("abort_outputs");
    q.delete();
    rsp_ready = 1'b1;
    @(posedge clk);
    #2;
    req_valid = 2'b00;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    check("no_rsp_after_abort", {31'd0, rsp_valid}, 32'd0);

    op0 = 4'd4; a0 = 8'h10; b0 = 8'h00;
    op1 = 4'd7; a1 = 8'h20; b1 = 8'h00;
    grant(2'b11, 2'b01, 16'h000F, 1'b0, 1'b0, 1'b0, 2, 2'b00);
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: req_valid  input  2  per-requester request strobe (bit i = requester i).
REQ-004 SHALL have ports: req_ready  output  2  one-hot grant/accept, bit i high for exactly the cycle requester i is accepted.
REQ-005 SHALL have ports: op0, op1  input  4 each  opcode; a0, b0, a1, b1  input  8 each  operands.
REQ-006 SHALL have ports: rsp_valid  output  1; rsp_ready  input  1; rsp_id  output  1  requester served; rsp_data  output  16; rsp_zero, rsp_carry, rsp_err  output  1 each.

Function
REQ-007 SHALL implement states IDLE, EXEC, MUL, DONE; leave IDLE only on an accept.
REQ-008 SHALL accept only in IDLE; with a single valid, grant it; with both valid, grant the requester not granted last (round-robin).
REQ-009 SHALL latch op, a, b and id on the accept edge; operand changes afterwards SHALL have no effect.
REQ-010 SHALL decode ops: 0 inv(~a), 1 andl, 2 equ(1 if a==b else 0), 3 orl, 4 dec(a-1), 5 add, 6 sub(a-b), 7 inc(a+1), 8 cmp(bit0 = a<b unsigned, bit1 = a==b), 9 muls, 10 neg(-a); 11-15 illegal.
REQ-011 SHALL, for single-cycle ops, go IDLE -> EXEC -> DONE: accept at cycle N, rsp_valid high from N+2.
REQ-012 SHALL compute muls as signed 8x8 -> 16-bit by shift-add, IDLE -> MUL (8 cycles) -> DONE: rsp_valid high from N+9.
REQ-013 SHALL zero-extend 8-bit results into rsp_data[15:8].
REQ-014 SHALL set rsp_carry to carry-out for add/inc, borrow for sub/dec, 0 for all other ops; rsp_zero SHALL equal (rsp_data == 0).
REQ-015 SHALL treat illegal ops as IDLE -> EXEC -> DONE with rsp_data = 0, rsp_err = 1, rsp_zero = 1, rsp_carry = 0.
REQ-016 SHALL hold rsp_valid and all rsp_* outputs stable in DONE until rsp_ready is high; DONE with rsp_ready -> IDLE, with no accept in that same cycle.
REQ-017 SHALL not assert req_ready while in EXEC, MUL or DONE, whatever req_valid is.

Reset
REQ-018 SHALL, on rst_n low, immediately enter IDLE with req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, and all flags 0.
REQ-019 SHALL reset the round-robin pointer so that requester 0 wins the first two-way tie.
REQ-020 SHALL, on reset during EXEC/MUL/DONE, discard the in-flight operation and never emit a response for it.

Configuration
REQ-021 SHALL, with ALU_SEQ_MULS_EN defined, implement muls per REQ-012.
REQ-022 SHALL, without ALU_SEQ_MULS_EN, omit the MUL state and multiplier logic and treat op 9 as illegal per REQ-015.

Structure
REQ-023 SHALL take opcode constants, the state encoding and the data width (8) from shared package alu_seq_pkg.
REQ-024 SHALL instantiate alu_decoder as its one sub-module to turn the latched op into one-hot operation enables.

Verification
REQ-025 Single add: req_valid=01, op0=5, a0=8'hF0, b0=8'h20 -> rsp_valid at N+2, rsp_id=0, rsp_data=16'h0010, rsp_carry=1, rsp_zero=0.
REQ-026 Tie: req_valid=11 from reset -> req_ready=01; after the response retires with both still valid -> req_ready=10.
REQ-027 muls (macro on): op1=9, a1=8'hFD (-3), b1=8'h07 -> rsp_valid at N+9, rsp_data=16'hFFEB, rsp_id=1.
REQ-028 Illegal/backpressure: op0=12 with rsp_ready=0 for 5 cycles -> rsp_err=1, rsp_data=0 held stable, no req_ready until rsp_ready=1.
REQ-029 Reset abort: rst_n low during MUL cycle 4 -> all outputs 0 at once, no response afterwards, next tie grants requester 0.
REQ-030 Macro off: op0=9 -> rsp_err=1 at N+2.
